// File: rtl/ripple_carry_adder_full_adder.sv
// Single-bit full adder cell built from xor/and/or gate primitives.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs continuously.
// Ports: a, b, cin (operand bits and carry in) -> s (sum bit), cout (carry out).
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;     // propagate: carry passes through when exactly one operand bit is set
    logic g;     // generate: both operand bits set
    logic pc;    // incoming carry propagated

    xor u_xor_p (p, a, b);
    xor u_xor_s (s, p, cin);
    and u_and_g (g, a, b);
    and u_and_pc (pc, p, cin);
    or  u_or_c (cout, g, pc);

endmodule

// File: rtl/ripple_carry_adder.sv
// WIDTH-bit ripple-carry adder, {c_out, sum} = a + b + c_in, result registered.
// Latency: 1 cycle from in_valid to out_valid; one operand set accepted per cycle.
// Backpressure: none; there is no ready, every valid input produces a result.
// Ports: clk, rst (sync, active-high), a, b, c_in, in_valid -> sum, c_out, out_valid,
//        and ovf (two's-complement overflow) only when macro RCA_OVF_EN is defined.
module ripple_carry_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
`ifdef RCA_OVF_EN
    output logic             ovf,
`endif
    output logic             out_valid
);

    // c[i] is the carry into bit i; c[WIDTH] is the carry out of the MSB.
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    assign c[0] = c_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (s[i]),
            .cout (c[i+1])
        );
    end

    // Reset wins over in_valid, so an operation presented during reset is dropped.
    // When in_valid is low only out_valid falls; the data registers hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum       <= '0;
            c_out     <= 1'b0;
            out_valid <= 1'b0;
`ifdef RCA_OVF_EN
            ovf       <= 1'b0;
`endif
        end else if (in_valid) begin
            sum       <= s;
            c_out     <= c[WIDTH];
            out_valid <= 1'b1;
`ifdef RCA_OVF_EN
            // Carry into and out of the sign bit disagree exactly on signed overflow.
            ovf       <= c[WIDTH] ^ c[WIDTH-1];
`endif
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ripple_carry_adder.sv
module tb_ripple_carry_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic       c_in;
    logic       in_valid;
    logic [3:0] sum;
    logic       c_out;
    logic       out_valid;
`ifdef RCA_OVF_EN
    logic       ovf;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ripple_carry_adder #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .in_valid  (in_valid),
        .sum       (sum),
        .c_out     (c_out),
`ifdef RCA_OVF_EN
        .ovf       (ovf),
`endif
        .out_valid (out_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs, clock once, then sample 1 time unit after the edge.
    task automatic step(input logic r, input logic v, input logic [3:0] ia,
                        input logic [3:0] ib, input logic ic);
        rst      = r;
        in_valid = v;
        a        = ia;
        b        = ib;
        c_in     = ic;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] exp5;
        int         sv;

        // Reset state
        step(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
        chk("reset_sum", {28'd0, sum}, 32'd0);
        chk("reset_cout", {31'd0, c_out}, 32'd0);
        chk("reset_vld", {31'd0, out_valid}, 32'd0);
`ifdef RCA_OVF_EN
        chk("reset_ovf", {31'd0, ovf}, 32'd0);
`endif

        // Exhaustive 512 vectors, one per cycle
        for (int ci = 0; ci < 2; ci++) begin
            for (int ia = 0; ia < 16; ia++) begin
                for (int ib = 0; ib < 16; ib++) begin
                    step(1'b0, 1'b1, 4'(ia), 4'(ib), 1'(ci));
                    exp5 = 5'(ia + ib + ci);
                    chk($sformatf("exh_%0d_%0d_%0d", ia, ib, ci), {27'd0, c_out, sum}, {27'd0, exp5});
                    chk("exh_vld", {31'd0, out_valid}, 32'd1);
                    chk("exh_noX", {31'd0, $isunknown({c_out, sum, out_valid})}, 32'd0);
`ifdef RCA_OVF_EN
                    sv = (ia >= 8 ? ia - 16 : ia) + (ib >= 8 ? ib - 16 : ib) + ci;
                    chk("exh_ovf", {31'd0, ovf}, (sv > 7 || sv < -8) ? 32'd1 : 32'd0);
`endif
                end
            end
        end

        // Carry ripple through every cell
        step(1'b0, 1'b1, 4'hF, 4'h0, 1'b1);
        chk("ripple_f_0_1", {27'd0, c_out, sum}, 32'h10);
        step(1'b0, 1'b1, 4'd9, 4'd7, 1'b0);
        chk("ripple_9_7_0", {27'd0, c_out, sum}, 32'h10);
        // Boundary: all-ones + all-ones + 1, then zeros
        step(1'b0, 1'b1, 4'hF, 4'hF, 1'b1);
        chk("max_sum", {27'd0, c_out, sum}, 32'h1F);
        step(1'b0, 1'b1, 4'h0, 4'h0, 1'b0);
        chk("zero_sum", {27'd0, c_out, sum}, 32'h00);

        // Reset held 2 cycles with valid operands present
        step(1'b1, 1'b1, 4'd5, 4'd3, 1'b0);
        chk("rst1_sum", {27'd0, c_out, sum}, 32'd0);
        chk("rst1_vld", {31'd0, out_valid}, 32'd0);
        step(1'b1, 1'b1, 4'd5, 4'd3, 1'b0);
        chk("rst2_sum", {27'd0, c_out, sum}, 32'd0);
        chk("rst2_vld", {31'd0, out_valid}, 32'd0);
        step(1'b0, 1'b1, 4'd5, 4'd3, 1'b0);
        chk("post_rst_sum", {27'd0, c_out, sum}, 32'd8);
        chk("post_rst_vld", {31'd0, out_valid}, 32'd1);

        // Hold: one valid result, then three idle cycles with changing operands
        step(1'b0, 1'b1, 4'd3, 4'd4, 1'b0);
        chk("hold_first_sum", {27'd0, c_out, sum}, 32'd7);
        chk("hold_first_vld", {31'd0, out_valid}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 4'(k + 9), 4'(15 - k), 1'b1);
            chk($sformatf("hold_sum_%0d", k), {27'd0, c_out, sum}, 32'd7);
            chk($sformatf("hold_vld_%0d", k), {31'd0, out_valid}, 32'd0);
        end

        // Mid-stream reset between two valid inputs
        step(1'b0, 1'b1, 4'd1, 4'd2, 1'b0);
        chk("mid_pre_sum", {27'd0, c_out, sum}, 32'd3);
        step(1'b1, 1'b1, 4'd6, 4'd6, 1'b0);
        chk("mid_rst_sum", {27'd0, c_out, sum}, 32'd0);
        chk("mid_rst_vld", {31'd0, out_valid}, 32'd0);
        step(1'b0, 1'b0, 4'd6, 4'd6, 1'b0);
        chk("mid_idle_sum", {27'd0, c_out, sum}, 32'd0);
        chk("mid_idle_vld", {31'd0, out_valid}, 32'd0);

`ifdef RCA_OVF_EN
        // Signed overflow cases
        step(1'b0, 1'b1, 4'd7, 4'd1, 1'b0);
        chk("ovf_7_1", {31'd0, ovf}, 32'd1);
        chk("ovf_7_1_sum", {27'd0, c_out, sum}, 32'h08);
        step(1'b0, 1'b1, 4'd8, 4'd8, 1'b0);
        chk("ovf_8_8", {31'd0, ovf}, 32'd1);
        chk("ovf_8_8_cout", {31'd0, c_out}, 32'd1);
        step(1'b0, 1'b0, 4'd3, 4'd2, 1'b0);
        chk("ovf_hold", {31'd0, ovf}, 32'd1);
        step(1'b0, 1'b1, 4'd3, 4'd2, 1'b0);
        chk("ovf_3_2", {31'd0, ovf}, 32'd0);
        chk("ovf_3_2_sum", {27'd0, c_out, sum}, 32'h05);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
